// File: rtl/ram64_copy_engine.sv
// ram64_copy_engine: copies a block of words within a single-port RAM.
// Each word takes one READ cycle (combinational RAM read, captured into a
// holding register) and one WRITE cycle, followed by a one-cycle DONE pulse.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : request a copy (honoured only in IDLE)
//   src_addr      : first source word address
//   dst_addr      : first destination word address
//   length        : words to copy, clamped to the RAM depth
//   busy          : high from the first READ cycle through the DONE cycle
//   done          : one-cycle completion pulse
//   mem_load      : RAM write enable
//   mem_addres    : RAM word address
//   mem_data_out  : RAM write data
//   mem_data_in   : RAM read data (valid in the cycle the address is driven)
module ram64_copy_engine #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addres,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   hold_q, hold_d;

    // Output registers, loaded with the values belonging to the next state
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load_q, load_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic [LEN_W-1:0]    length_eff_c;
    logic                last_word_c;

    // Requests longer than the RAM are clamped to the full RAM
    assign length_eff_c = (length > MAX_LEN) ? MAX_LEN : length;

    assign last_word_c  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    // Next-state, operand and output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        hold_d  = hold_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load_d  = 1'b0;
        addr_d  = '0;
        dout_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length_eff_c;
                    idx_d   = '0;
                    state_d = (length_eff_c == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                hold_d  = mem_data_in;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word_c) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address sums wrap naturally at the RAM depth
        case (state_d)
            ST_READ: begin
                busy_d = 1'b1;
                addr_d = src_d + idx_d;
            end
            ST_WRITE: begin
                busy_d = 1'b1;
                load_d = 1'b1;
                addr_d = dst_d + idx_d;
                dout_d = hold_d;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    // A reset arriving in a WRITE cycle must stop that write from committing
    // on the same edge, so the enable is masked by rst directly.
    assign mem_load     = load_q & ~rst;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_addres   = addr_q;
    assign mem_data_out = dout_q;

endmodule

// File: tb/tb_ram64_copy_engine.sv
module tb_ram64_copy_engine;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic          load;
        logic          dn;
        logic          chk_data;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          mem_load;
    logic [AW-1:0] mem_addres;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_data_in;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    rec_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cycle_cnt   = 0;
    int wr_cnt      = 0;
    int done_cyc    = -1;

    always #5 clk = ~clk;

    ram64_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_load     (mem_load),
        .mem_addres   (mem_addres),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in)
    );

    // RAM: combinational read, write on the rising edge
    assign mem_data_in = ram[mem_addres];

    always @(posedge clk) begin
        if (mem_load)
            ram[mem_addres] <= mem_data_out;
        else if (pre_we)
            ram[pre_addr] <= pre_data;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cycle_cnt, $time);
        end
    endtask

    // Monitor: pops one expected record per busy cycle, checks idle outputs otherwise
    always @(negedge clk) begin
        rec_t r;
        if (rst === 1'b1) begin
            check("load_during_rst", 32'(mem_load), 32'd0);
        end else if (rst === 1'b0) begin
            if (mem_load) wr_cnt <= wr_cnt + 1;
            if (done) done_cyc <= cycle_cnt;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy", 32'(busy), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("load", 32'(mem_load), 32'(r.load));
                    check("done", 32'(done), 32'(r.dn));
                    check("addr", 32'(mem_addres), 32'(r.addr));
                    if (r.chk_data) check("wdata", 32'(mem_data_out), 32'(r.data));
                end
            end else begin
                check("idle_outputs", {13'd0, done, mem_load, mem_data_out, 1'b0, mem_addres}, 32'd0);
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        shadow[a] = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Called at posedge+1 in an IDLE cycle; start is sampled at the next edge.
    task automatic run_copy(input int s, input int d, input int len, input int glitch_at, input int abort_at);
        int   n, limit, last, c, w0, exp_writes;
        rec_t r;
        logic [DW-1:0] v;
        n          = (len > DEPTH) ? DEPTH : len;
        limit      = (abort_at > 0) ? abort_at - 1 : 2 * n + 1;
        last       = (abort_at > 0) ? abort_at : 2 * n + 1;
        exp_writes = 0;
        // Reference: word i is read after words 0..i-1 have been written
        for (int i = 0; i < n; i++) begin
            if (2 * i + 1 <= limit) begin
                r = '{load: 1'b0, dn: 1'b0, chk_data: 1'b0, addr: AW'((s + i) % DEPTH), data: '0};
                exp_q.push_back(r);
            end
            v = shadow[(s + i) % DEPTH];
            if (2 * i + 2 <= limit) begin
                shadow[(d + i) % DEPTH] = v;
                r = '{load: 1'b1, dn: 1'b0, chk_data: 1'b1, addr: AW'((d + i) % DEPTH), data: v};
                exp_q.push_back(r);
                exp_writes++;
            end
        end
        if (2 * n + 1 <= limit) begin
            r = '{load: 1'b0, dn: 1'b1, chk_data: 1'b1, addr: '0, data: '0};
            exp_q.push_back(r);
        end

        c        = cycle_cnt;
        w0       = wr_cnt;
        done_cyc = -1;
        start    = 1'b1;
        src_addr = AW'(s);
        dst_addr = AW'(d);
        length   = (AW+1)'(len);
        @(posedge clk); #1;
        for (int j = 1; j <= last; j++) begin
            start = (j == glitch_at);
            rst   = (j == abort_at);
            src_addr = AW'($urandom);
            dst_addr = AW'($urandom);
            length   = (AW+1)'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("write_count", 32'(wr_cnt - w0), 32'(exp_writes));
        if (abort_at > 0) check("no_done_after_rst", 32'(done_cyc), 32'hFFFF_FFFF);
        else              check("done_cycle", 32'(done_cyc - c), 32'(last));
        for (int a = 0; a < DEPTH; a++) begin
            if (ram[a] !== shadow[a]) check($sformatf("ram[%0d]", a), 32'(ram[a]), 32'(shadow[a]));
        end
        vectors++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s, d, len, g;
        rst = 1'b1; start = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        src_addr = '0; dst_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load", 32'(mem_load), 32'd0);
        check("rst_addr", 32'(mem_addres), 32'd0);
        check("rst_dout", 32'(mem_data_out), 32'd0);

        for (int a = 0; a < DEPTH; a++) poke(a, DW'($urandom));

        // Basic copy with exact done timing (cycle 9)
        poke(4, 16'h1111); poke(5, 16'h2222); poke(6, 16'h3333); poke(7, 16'h4444);
        run_copy(4, 20, 4, 0, 0);
        // Source wraps past the top of the RAM
        run_copy(62, 10, 4, 0, 0);
        // Zero length, then clamped length (back-to-back)
        run_copy(5, 30, 0, 0, 0);
        run_copy(7, 0, 100, 0, 0);
        run_copy(33, 40, 127, 0, 0);
        // Overlapping forward copy replicates the first word
        poke(0, 16'hABCD);
        run_copy(0, 1, 3, 0, 0);
        // start pulsed while busy is ignored
        run_copy(10, 40, 6, 4, 0);
        run_copy(50, 2, 3, 7, 0);
        // Reset in the WRITE cycle of word 2 of a 5-word copy
        run_copy(20, 50, 5, 0, 6);
        run_copy(12, 44, 2, 0, 0);

        for (int k = 0; k < 25; k++) begin
            s   = int'($urandom_range(0, DEPTH - 1));
            d   = int'($urandom_range(0, DEPTH - 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
            g   = ($urandom_range(0, 2) == 0) ? 2 : 0;
            if (k % 7 == 6 && len > 1) run_copy(s, d, len, 0, int'($urandom_range(1, 2 * len)));
            else                       run_copy(s, d, len, g, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram64_copy_engine.md
RAM64_COPY_ENGINE -- requirements
Module: ram64_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM word-address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 16, RAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a block copy; sampled only in IDLE.
REQ-006 SHALL have port src_addr  input  ADDR_W  first source word address.
REQ-007 SHALL have port dst_addr  input  ADDR_W  first destination word address.
REQ-008 SHALL have port length  input  ADDR_W+1  words to copy (0..127).
REQ-009 SHALL have port busy  output  1  high from the first READ cycle through the DONE cycle.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_load  output  1  RAM write enable; connects to the RAM load input.
REQ-012 SHALL have port mem_addres  output  ADDR_W  RAM address; connects to the RAM addres input.
REQ-013 SHALL have port mem_data_out  output  DATA_W  write data; connects to the RAM data_in input.
REQ-014 SHALL have port mem_data_in  input  DATA_W  read data; connects to the RAM data_out output.

Function
REQ-015 SHALL treat the RAM read as combinational: mem_data_in is valid in the same cycle mem_addres is driven.
REQ-016 SHALL treat a RAM write as committed at the rising edge where mem_load=1.
REQ-017 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-018 SHALL, in IDLE with start=1, latch src_addr, dst_addr and length_eff, clear word index idx, and go to READ. If length_eff=0 it SHALL go to DONE instead.
REQ-019 SHALL compute length_eff as min(length, 64); values 65..127 are clamped to 64.
REQ-020 SHALL, in READ, drive mem_addres=(src+idx) mod 64 and mem_load=0, capture mem_data_in into hold_reg at the clock edge, and go to WRITE.
REQ-021 SHALL, in WRITE, drive mem_addres=(dst+idx) mod 64, mem_data_out=hold_reg and mem_load=1.
REQ-022 SHALL, at the edge ending WRITE, go to DONE if idx=length_eff-1; otherwise it SHALL increment idx and go to READ.
REQ-023 SHALL, in DONE, drive done=1 for exactly one cycle and then go to IDLE.
REQ-024 SHALL wrap address arithmetic modulo 2^ADDR_W, so src=62 with length 4 reads 62, 63, 0, 1.
REQ-025 SHALL copy in ascending index order. For overlapping regions with dst>src, replicated data is the defined result; no reordering is performed.
REQ-026 SHALL ignore start while not in IDLE and SHALL NOT latch new operands during a copy.
REQ-027 SHALL finish a copy of N>0 words in 2N cycles of READ/WRITE, then 1 DONE cycle. With start sampled at edge 0, done is high in cycle 2N+1.
REQ-028 SHALL drive mem_load=0 in IDLE, READ and DONE.
REQ-029 SHALL drive mem_addres=0 and mem_data_out=0 in IDLE and DONE.
REQ-030 SHALL allow start to be sampled in the cycle immediately after DONE, giving back-to-back copies with no idle gap beyond that one IDLE cycle.

Reset
REQ-031 SHALL, on rst=1 at a rising edge, enter IDLE with idx=0, hold_reg=0 and all latched operands 0.
REQ-032 SHALL hold busy=0, done=0, mem_load=0, mem_addres=0 and mem_data_out=0 from the cycle after a reset edge.
REQ-033 SHALL give rst priority over start and over every state transition.
REQ-034 SHALL NOT issue any further write after a reset during a copy; words already written stay written, and no done pulse is produced.

Verification
REQ-035 SHALL pass: preload RAM[4..7]=0x1111,0x2222,0x3333,0x4444; start with src=4, dst=20, len=4 -> RAM[20..23] equal those values, done high in cycle 9, RAM[4..7] unchanged.
REQ-036 SHALL pass: src=62, dst=10, len=4 -> reads at 62, 63, 0, 1; RAM[10..13] receive those words.
REQ-037 SHALL pass: len=0 -> mem_load is never asserted and done pulses in cycle 1; len=100 -> exactly 64 writes.
REQ-038 SHALL pass: RAM[0]=0xABCD, src=0, dst=1, len=3 (overlap) -> RAM[1..3] all 0xABCD.
REQ-039 SHALL pass: start pulsed again during a busy copy -> ignored, and the first copy's results are intact.
REQ-040 SHALL pass: rst asserted in the WRITE cycle of word 2 of a 5-word copy -> IDLE the next cycle, only words 0 and 1 written, no done pulse.
